// File: rtl/hzv_pkg.sv
// Shared definitions for the frequency meter: sequencer states, gate range
// encodings and gate lengths. The latch/display stage imports this too, for
// decimal point and D1/D2 decoding.
package hzv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SETTLE,
    GATE,
    HOLD,
    LATCH
  } state_t;

  typedef logic [1:0] range_t;

  localparam range_t RANGE_1S    = 2'd0;
  localparam range_t RANGE_100MS = 2'd1;
  localparam range_t RANGE_10MS  = 2'd2;

  localparam int GATE_MS_1S    = 1000;
  localparam int GATE_MS_100MS = 100;
  localparam int GATE_MS_10MS  = 10;

  // Gate length in milliseconds for a range code. Code 3 is never
  // produced, so it falls back to the 1 s gate.
  function automatic int gate_ms(input range_t r);
    int ms;
    case (r)
      RANGE_100MS: ms = GATE_MS_100MS;
      RANGE_10MS:  ms = GATE_MS_10MS;
      default:     ms = GATE_MS_1S;
    endcase
    return ms;
  endfunction

  // Autoranging step: overflow shortens the gate, a leading zero lengthens
  // it. Overflow takes priority. Both directions saturate.
  function automatic range_t step_range(input range_t r, input logic ovf,
                                        input logic under);
    range_t nr;
    nr = r;
    if (ovf) begin
      if (r != RANGE_10MS) nr = r + 2'd1;
    end else if (under) begin
      if (r != RANGE_1S) nr = r - 2'd1;
    end
    return nr;
  endfunction

endpackage

// File: rtl/gate_timer_phase_timer.sv
// Loadable down-counter that times each sequencer phase. A load of N gives
// a phase lasting exactly N clocks: tc is high on the last of them.
module phase_timer #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count;

  // Reload on command, otherwise count down and park at zero
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign tc = (count == W'(1));

endmodule

// File: rtl/gate_timer.sv
// Measurement sequencer for the TTL frequency meter. Generates counter
// clear/gate strobes and the display latch strobe, and autoranges the gate
// length from the counter's overflow and leading-zero flags.
module gate_timer
  import hzv_pkg::*;
#(
  parameter int TICK_DIV   = 50000,
  parameter int CLR_CYC    = 4,
  parameter int SETTLE_CYC = 4,
  parameter int HOLD_CYC   = 8,
  parameter int LATCH_CYC  = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic       ovf,
  input  logic       under,
  output logic       clear,
  output logic       enable,
  output logic       latch,
  output logic [1:0] range,
  output logic       done
);

  // Wide enough for the 1 s gate terminal count
  localparam int CNT_W = $clog2(1000 * TICK_DIV + 1);

  state_t             state;
  range_t             range_q;
  range_t             next_range;
  logic               ovf_s1, ovf_s2;
  logic               under_s1, under_s2;
  logic               load;
  logic [CNT_W-1:0]   load_val;
  logic               tc;

  phase_timer #(.W(CNT_W)) u_phase_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .tc       (tc)
  );

  // Two-flop synchronizers for the test-clock-domain flags
  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_s1   <= 1'b0;
      ovf_s2   <= 1'b0;
      under_s1 <= 1'b0;
      under_s2 <= 1'b0;
    end else begin
      ovf_s1   <= ovf;
      ovf_s2   <= ovf_s1;
      under_s1 <= under;
      under_s2 <= under_s1;
    end
  end

  // Reload the phase timer with the length of the state being entered
  always_comb begin
    load     = 1'b0;
    load_val = '0;
    case (state)
      IDLE: begin
        if (run) begin
          load     = 1'b1;
          load_val = CNT_W'(CLR_CYC);
        end
      end
      CLEAR: begin
        if (tc) begin
          load     = 1'b1;
          load_val = CNT_W'(SETTLE_CYC);
        end
      end
      SETTLE: begin
        if (tc) begin
          load     = 1'b1;
          load_val = CNT_W'(gate_ms(range_q) * TICK_DIV);
        end
      end
      GATE: begin
        if (tc) begin
          load     = 1'b1;
          load_val = CNT_W'(HOLD_CYC);
        end
      end
      HOLD: begin
        if (tc) begin
          load     = 1'b1;
          load_val = CNT_W'(LATCH_CYC);
        end
      end
      LATCH: begin
        if (tc && run) begin
          load     = 1'b1;
          load_val = CNT_W'(CLR_CYC);
        end
      end
      default: begin
        load     = 1'b0;
        load_val = '0;
      end
    endcase
  end

  // Sequencer: strobes are registered copies of the current state, so every
  // strobe (and the exported range) trails the state by one clock together
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      range_q    <= RANGE_1S;
      next_range <= RANGE_1S;
      clear      <= 1'b1;
      enable     <= 1'b0;
      latch      <= 1'b0;
      done       <= 1'b0;
      range      <= RANGE_1S;
    end else begin
      clear  <= (state == IDLE) || (state == CLEAR);
      enable <= (state == GATE);
      latch  <= (state == LATCH);
      done   <= (state == LATCH) && tc;
      range  <= range_q;
      case (state)
        IDLE: begin
          if (run) state <= CLEAR;
        end
        CLEAR: begin
          if (tc) state <= SETTLE;
        end
        SETTLE: begin
          if (tc) state <= GATE;
        end
        GATE: begin
          if (tc) state <= HOLD;
        end
        HOLD: begin
          if (tc) begin
            next_range <= step_range(range_q, ovf_s2, under_s2);
            state      <= LATCH;
          end
        end
        LATCH: begin
          if (tc) begin
            range_q <= next_range;
            state   <= run ? CLEAR : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_timer.sv
// Self-checking bench for gate_timer with TICK_DIV=10. The driver queues the
// expected outcome of each measurement; the monitor measures strobe widths
// from the pins and compares them at every done pulse.
module tb_gate_timer;
  import hzv_pkg::*;

  typedef struct {
    int     gate;
    range_t r_before;
    range_t r_after;
    int     clr_len;
  } meas_t;

  logic       clock;
  logic       reset;
  logic       run;
  logic       ovf;
  logic       under;
  logic       clear;
  logic       enable;
  logic       latch;
  logic [1:0] range;
  logic       done;

  int errors = 0;
  int checks = 0;
  int onehot_bad = 0;
  meas_t exp_q[$];

  gate_timer #(.TICK_DIV(10)) dut (
    .clock  (clock),
    .reset  (reset),
    .run    (run),
    .ovf    (ovf),
    .under  (under),
    .clear  (clear),
    .enable (enable),
    .latch  (latch),
    .range  (range),
    .done   (done)
  );

  // 100 MHz system clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic finishRun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // Queue the expected outcome of one measurement and drive its flags
  task automatic applyStimulus(input bit o, input bit u, input int gate,
                               input range_t rb, input range_t ra, input int clr);
    meas_t m;
    m.gate = gate;
    m.r_before = rb;
    m.r_after = ra;
    m.clr_len = clr;
    exp_q.push_back(m);
    ovf = o;
    under = u;
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!done && n < 12000);
    if (!done) begin
      checkOutput("done_timeout", 0, 1);
      finishRun();
    end
  endtask

  task automatic waitEnable();
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!enable && n < 200);
    if (!enable) begin
      checkOutput("enable_timeout", 0, 1);
      finishRun();
    end
  endtask

  // Monitor: measure run lengths of each strobe phase and score each done
  int  clr_cnt, gap1, en_cnt, gap2, lat_cnt;
  bit  prev_clear;
  bit  after_pending;
  range_t after_range;
  always @(negedge clock) begin
    if ((int'(clear) + int'(enable) + int'(latch)) > 1) onehot_bad++;
    if (after_pending) begin
      after_pending = 1'b0;
      checkOutput("range_after", int'(range), int'(after_range));
      checkOutput("done_width", int'(done), 0);
    end
    if (reset) begin
      clr_cnt = 0; gap1 = 0; en_cnt = 0; gap2 = 0; lat_cnt = 0;
      prev_clear = 1'b1;
    end else begin
      if (clear && !prev_clear) begin
        clr_cnt = 0; gap1 = 0; en_cnt = 0; gap2 = 0; lat_cnt = 0;
      end
      if (clear) clr_cnt++;
      else if (enable) en_cnt++;
      else if (latch) lat_cnt++;
      else if (en_cnt == 0) gap1++;
      else gap2++;
      prev_clear = clear;
      if (done) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          meas_t m;
          m = exp_q.pop_front();
          checkOutput("gate_len", en_cnt, m.gate);
          checkOutput("settle_len", gap1, 4);
          checkOutput("hold_len", gap2, 8);
          checkOutput("latch_len", lat_cnt, 4);
          checkOutput("range_during", int'(range), int'(m.r_before));
          if (m.clr_len != 0) checkOutput("clear_len", clr_cnt, m.clr_len);
          after_pending = 1'b1;
          after_range = m.r_after;
        end
      end
    end
  end

  // Directed sequence of measurements
  initial begin
    int n;
    int en_seen;
    reset = 1'b1;
    run = 1'b0;
    ovf = 1'b0;
    under = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_clear", int'(clear), 1);
    checkOutput("rst_enable", int'(enable), 0);
    checkOutput("rst_latch", int'(latch), 0);
    checkOutput("rst_range", int'(range), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_state", int'(dut.state), int'(IDLE));
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // First measurement: also time enable from the IDLE->CLEAR edge
    applyStimulus(1'b0, 1'b0, 10000, RANGE_1S, RANGE_1S, 0);
    run = 1'b1;
    @(posedge clock);
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!enable && n < 50);
    checkOutput("enable_latency", n, 9);
    waitDone();

    applyStimulus(1'b0, 1'b0, 10000, RANGE_1S, RANGE_1S, 4);
    waitDone();
    applyStimulus(1'b1, 1'b0, 10000, RANGE_1S, RANGE_100MS, 4);
    waitDone();
    applyStimulus(1'b1, 1'b0, 1000, RANGE_100MS, RANGE_10MS, 4);
    waitDone();
    applyStimulus(1'b1, 1'b0, 100, RANGE_10MS, RANGE_10MS, 4);
    waitDone();
    applyStimulus(1'b0, 1'b1, 100, RANGE_10MS, RANGE_100MS, 4);
    waitDone();
    applyStimulus(1'b0, 1'b1, 1000, RANGE_100MS, RANGE_1S, 4);
    waitDone();
    applyStimulus(1'b0, 1'b1, 10000, RANGE_1S, RANGE_1S, 4);
    waitDone();
    applyStimulus(1'b1, 1'b1, 10000, RANGE_1S, RANGE_100MS, 4);
    waitDone();

    // Overflow glitch during the gate, gone before the sample point
    applyStimulus(1'b0, 1'b0, 1000, RANGE_100MS, RANGE_100MS, 4);
    waitEnable();
    repeat (100) @(negedge clock);
    ovf = 1'b1;
    repeat (50) @(negedge clock);
    ovf = 1'b0;
    waitDone();

    // run dropped mid-gate: measurement completes, then IDLE
    applyStimulus(1'b0, 1'b0, 1000, RANGE_100MS, RANGE_100MS, 4);
    waitEnable();
    repeat (10) @(negedge clock);
    run = 1'b0;
    waitDone();
    repeat (5) @(negedge clock);
    checkOutput("stop_clear", int'(clear), 1);
    checkOutput("stop_state", int'(dut.state), int'(IDLE));
    en_seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (enable) en_seen++;
    end
    checkOutput("stop_no_enable", en_seen, 0);

    // Reset in the middle of a gate
    run = 1'b1;
    waitEnable();
    repeat (20) @(negedge clock);
    reset = 1'b1;
    run = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("midrst_enable", int'(enable), 0);
    checkOutput("midrst_clear", int'(clear), 1);
    checkOutput("midrst_range", int'(range), 0);
    checkOutput("midrst_state", int'(dut.state), int'(IDLE));
    checkOutput("midrst_latch", int'(latch), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);

    checkOutput("pending_meas", exp_q.size(), 0);
    checkOutput("onehot_violations", onehot_bad, 0);
    finishRun();
  end

endmodule
